// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator.
// Produces registered hs/vs/de, pixel coordinates and line/frame strobes,
// all describing the same pixel. A clock divider allows several clocks per pixel.
// Optional feature macro: VGA_TIMING_BLINK_EN (frame counter and blink output).
// With the macro undefined, frame_cnt_o and blink_o are tied to 0.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 400,
  parameter int V_FRONT   = 12,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 35,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b1,
  parameter int CLK_DIV   = 1,
  parameter int X_WIDTH   = 10,
  parameter int Y_WIDTH   = 10
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               enable_i,
  output logic               hs_o,
  output logic               vs_o,
  output logic               de_o,
  output logic [X_WIDTH-1:0] x_o,
  output logic [Y_WIDTH-1:0] y_o,
  output logic               pix_en_o,
  output logic               line_start_o,
  output logic               frame_start_o,
  output logic [4:0]         frame_cnt_o,
  output logic               blink_o
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [X_WIDTH-1:0] X_LAST   = X_WIDTH'(H_TOTAL - 1);
  localparam logic [X_WIDTH-1:0] X_VIS    = X_WIDTH'(H_VISIBLE);
  localparam logic [X_WIDTH-1:0] X_HS_BEG = X_WIDTH'(H_VISIBLE + H_FRONT);
  localparam logic [X_WIDTH-1:0] X_HS_END = X_WIDTH'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [Y_WIDTH-1:0] Y_LAST   = Y_WIDTH'(V_TOTAL - 1);
  localparam logic [Y_WIDTH-1:0] Y_VIS    = Y_WIDTH'(V_VISIBLE);
  localparam logic [Y_WIDTH-1:0] Y_VS_BEG = Y_WIDTH'(V_VISIBLE + V_FRONT);
  localparam logic [Y_WIDTH-1:0] Y_VS_END = Y_WIDTH'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DIV_W-1:0]   div_q, div_d;
  logic [X_WIDTH-1:0] x_q, x_d;
  logic [Y_WIDTH-1:0] y_q, y_d;
  logic               hs_q, vs_q, de_q;
  logic               hs_d, vs_d, de_d;
  logic               pix_en_q, line_start_q, frame_start_q;
  logic               tick;
  logic               new_line, new_frame;

  // Next pixel position and the levels that belong to it.
  always_comb begin
    tick      = enable_i && (div_q == DIV_LAST);
    div_d     = div_q;
    if (tick) begin
      div_d = '0;
    end else if (enable_i) begin
      div_d = div_q + DIV_W'(1);
    end
    x_d       = (x_q == X_LAST) ? '0 : x_q + X_WIDTH'(1);
    y_d       = y_q;
    if (x_q == X_LAST) begin
      y_d = (y_q == Y_LAST) ? '0 : y_q + Y_WIDTH'(1);
    end
    new_line  = (x_d == '0);
    new_frame = new_line && (y_d == '0);
    de_d      = (x_d < X_VIS) && (y_d < Y_VIS);
    hs_d      = ((x_d >= X_HS_BEG) && (x_d < X_HS_END)) ? HS_POL : ~HS_POL;
    vs_d      = ((y_d >= Y_VS_BEG) && (y_d < Y_VS_END)) ? VS_POL : ~VS_POL;
  end

  // Divider, raster position and registered levels advance together on each pixel tick.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q         <= '0;
      x_q           <= X_LAST;
      y_q           <= Y_LAST;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      de_q          <= 1'b0;
      pix_en_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      pix_en_q      <= tick;
      line_start_q  <= tick && new_line;
      frame_start_q <= tick && new_frame;
      if (tick) begin
        x_q  <= x_d;
        y_q  <= y_d;
        hs_q <= hs_d;
        vs_q <= vs_d;
        de_q <= de_d;
      end
    end
  end

`ifdef VGA_TIMING_BLINK_EN
  logic [4:0] frame_cnt_q;

  // Frame counter steps on the same edge that raises frame_start.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_cnt_q <= '0;
    end else if (tick && new_frame) begin
      frame_cnt_q <= frame_cnt_q + 5'd1;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
  assign blink_o     = frame_cnt_q[4];
`else
  assign frame_cnt_o = 5'd0;
  assign blink_o     = 1'b0;
`endif

  assign hs_o          = hs_q;
  assign vs_o          = vs_q;
  assign de_o          = de_q;
  assign x_o           = x_q;
  assign y_o           = y_q;
  assign pix_en_o      = pix_en_q;
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-geometry instance and a small CLK_DIV=3 instance,
// compared every clock against a closed-form raster model (pixel count -> x/y/levels).
module tb_vga_timing_gen;

  localparam int S_HV = 8, S_HF = 2, S_HS = 2, S_HB = 2;
  localparam int S_VV = 4, S_VF = 1, S_VS = 1, S_VB = 1;
  localparam int S_DIV = 3;
  localparam int D_DIV = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en_def, en_sml;

  logic       hs_d, vs_d, de_d, pe_d, ls_d, fs_d, bl_d;
  logic [9:0] x_d, y_d;
  logic [4:0] fc_d;
  logic       hs_s, vs_s, de_s, pe_s, ls_s, fs_s, bl_s;
  logic [3:0] x_s;
  logic [2:0] y_s;
  logic [4:0] fc_s;

  vga_timing_gen dut_def (
    .clk_i(clk), .rst_i(rst), .enable_i(en_def),
    .hs_o(hs_d), .vs_o(vs_d), .de_o(de_d), .x_o(x_d), .y_o(y_d),
    .pix_en_o(pe_d), .line_start_o(ls_d), .frame_start_o(fs_d),
    .frame_cnt_o(fc_d), .blink_o(bl_d)
  );

  vga_timing_gen #(
    .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
    .HS_POL(1'b0), .VS_POL(1'b1), .CLK_DIV(S_DIV), .X_WIDTH(4), .Y_WIDTH(3)
  ) dut_sml (
    .clk_i(clk), .rst_i(rst), .enable_i(en_sml),
    .hs_o(hs_s), .vs_o(vs_s), .de_o(de_s), .x_o(x_s), .y_o(y_s),
    .pix_en_o(pe_s), .line_start_o(ls_s), .frame_start_o(fs_s),
    .frame_cnt_o(fc_s), .blink_o(bl_s)
  );

  typedef struct {
    int x; int y;
    bit hs; bit vs; bit de; bit pe; bit ls; bit fs;
    int fc; bit bl;
  } exp_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned n_def, n_sml;
  bit          tk_def, tk_sml;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Raster state from the number of enabled clocks since reset.
  function automatic exp_t model(input int unsigned n, input bit tick,
                                 input int hv, input int hf, input int hsw, input int hb,
                                 input int vv, input int vf, input int vsw, input int vb,
                                 input int div);
    exp_t e;
    int ht, vt, fl, pix, p;
    ht   = hv + hf + hsw + hb;
    vt   = vv + vf + vsw + vb;
    fl   = ht * vt;
    pix  = int'(n) / div;
    p    = (pix + fl - 1) % fl;
    e.x  = p % ht;
    e.y  = p / ht;
    e.de = (e.x < hv) && (e.y < vv);
    e.hs = !((e.x >= hv + hf) && (e.x < hv + hf + hsw));
    e.vs = (e.y >= vv + vf) && (e.y < vv + vf + vsw);
    e.pe = tick;
    e.ls = tick && (e.x == 0);
    e.fs = tick && (p == 0);
`ifdef VGA_TIMING_BLINK_EN
    e.fc = ((pix + fl - 1) / fl) % 32;
    e.bl = e.fc >= 16;
`else
    e.fc = 0;
    e.bl = 1'b0;
`endif
    return e;
  endfunction

  task automatic verify();
    exp_t ed, es;
    ed = model(n_def, tk_def, 640, 16, 96, 48, 400, 12, 2, 35, D_DIV);
    es = model(n_sml, tk_sml, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, S_DIV);
    check("def.x", x_d, ed.x);         check("def.y", y_d, ed.y);
    check("def.hs", hs_d, ed.hs);      check("def.vs", vs_d, ed.vs);
    check("def.de", de_d, ed.de);      check("def.pix_en", pe_d, ed.pe);
    check("def.line_start", ls_d, ed.ls);
    check("def.frame_start", fs_d, ed.fs);
    check("def.frame_cnt", fc_d, ed.fc); check("def.blink", bl_d, ed.bl);
    check("sml.x", x_s, es.x);         check("sml.y", y_s, es.y);
    check("sml.hs", hs_s, es.hs);      check("sml.vs", vs_s, es.vs);
    check("sml.de", de_s, es.de);      check("sml.pix_en", pe_s, es.pe);
    check("sml.line_start", ls_s, es.ls);
    check("sml.frame_start", fs_s, es.fs);
    check("sml.frame_cnt", fc_s, es.fc); check("sml.blink", bl_s, es.bl);
  endtask

  // One clock: advance the model with the enables seen at the edge, then compare.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      n_def = 0; n_sml = 0; tk_def = 1'b0; tk_sml = 1'b0;
    end else begin
      tk_def = 1'b0;
      tk_sml = 1'b0;
      if (en_def) begin
        n_def++;
        tk_def = (n_def % D_DIV) == 0;
      end
      if (en_sml) begin
        n_sml++;
        tk_sml = (n_sml % S_DIV) == 0;
      end
    end
    #1;
    verify();
  endtask

  initial begin
    int hs0, de1, ls_cnt;
    bit found;
    rst = 1'b1; en_def = 1'b1; en_sml = 1'b1;
    n_def = 0; n_sml = 0; tk_def = 1'b0; tk_sml = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    // First pixel after reset release.
    step();
    check("t1.pix_en", pe_d, 1); check("t1.x", x_d, 0); check("t1.y", y_d, 0);
    check("t1.de", de_d, 1); check("t1.line_start", ls_d, 1);
    check("t1.frame_start", fs_d, 1); check("t1.hs", hs_d, 1); check("t1.vs", vs_d, 0);

    // Rest of line 0: sync width, visible width, no extra line strobes.
    hs0 = 0; de1 = 0; ls_cnt = 0;
    for (int i = 0; i < 799; i++) begin
      step();
      hs0    += (hs_d == 1'b0) ? 1 : 0;
      de1    += (de_d == 1'b1) ? 1 : 0;
      ls_cnt += (ls_d == 1'b1) ? 1 : 0;
    end
    check("t2.hs_low_clocks", hs0, 96);
    check("t2.de_high_rest", de1, 639);
    check("t2.ls_inside_line", ls_cnt, 0);
    step();
    check("t2.line_period", ls_d, 1);
    check("t2.line1_y", y_d, 1);

    // Freeze the default raster at x=100 for 10 clocks.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      found = (x_d == 10'd100);
    end
    check("t5.reach_x100", found, 1);
    en_def = 1'b0;
    repeat (10) step();
    check("t5.frozen_x", x_d, 100);
    en_def = 1'b1;
    step();
    check("t5.resume_x", x_d, 101);

    // Randomised enables on both instances.
    for (int i = 0; i < 14000; i++) begin
      en_def = ($urandom_range(0, 4) != 0);
      en_sml = ($urandom_range(0, 4) != 0);
      step();
    end

    // Asynchronous reset mid-line on the small raster.
    en_def = 1'b1; en_sml = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      found = (y_s == 3'd2) && (x_s == 4'd5) && pe_s;
    end
    check("t6.reach_y2", found, 1);
    #2 rst = 1'b1;
    #1;
    n_def = 0; n_sml = 0; tk_def = 1'b0; tk_sml = 1'b0;
    verify();
    check("t6.async_x", x_s, 13);
    check("t6.async_y", y_s, 6);
    repeat (2) step();
    rst = 1'b0;
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
